ed_stats_collector: RTL and testbench

- Sits directly downstream of the 64x64 Karatsuba approximate multiplier; consumes its 128-bit product alongside the exact product of the same operands.
- Computes the per-sample error distance ED = |P_approx - P_exact| over a programmed number of samples.
- Accumulates sum of ED, max ED and count of erroneous samples; these feed MED/NMED/error-rate characterisation of the approximate multiplier.
- Sequential: valid/ready input handshake, 2-stage pipeline, IDLE/RUN/DRAIN/DONE FSM.

---
 rtl/ed_stats_pkg.sv | 12 +
 rtl/error_distance.sv | 15 +
 rtl/ed_stats_collector.sv | 96 +++++++++
 tb/tb_ed_stats_collector.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ed_stats_pkg.sv
// ed_stats_pkg: shared FSM state type and default widths for error-distance statistics
// Contents:
//   state_t    - collector FSM state, 2-bit encoding
//   DEF_PW     - product width (2 x 64-bit operand)
//   DEF_CNT_W  - sample counter width
//   DEF_SUM_W  - ED accumulator width (DEF_PW + DEF_CNT_W, cannot overflow)
package ed_stats_pkg;
    localparam int DEF_PW    = 128;
    localparam int DEF_CNT_W = 32;
    localparam int DEF_SUM_W = DEF_PW + DEF_CNT_W;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;
endpackage

// File: rtl/error_distance.sv
// error_distance: unsigned absolute difference |a - b|
// Ports:
//   a, b  in  W  unsigned operands
//   d     out W  |a - b|
module error_distance
    import ed_stats_pkg::*;
#(
    parameter int W = DEF_PW
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] d
);
    assign d = (a >= b) ? a - b : b - a;
endmodule

// File: rtl/ed_stats_collector.sv
// ed_stats_collector: accumulates error-distance statistics of an approximate multiplier
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   start, num_samples     start pulse and sample count latched for the run
//   in_valid, in_ready     sample handshake
//   p_approx, p_exact      approximate and exact products of the same operands
//   busy, done             run in progress / statistics final and stable
//   sample_count           samples fully processed
//   err_count              samples with nonzero ED
//   sum_ed, max_ed         sum and maximum of ED
module ed_stats_collector
    import ed_stats_pkg::*;
#(
    parameter int PW    = DEF_PW,
    parameter int CNT_W = DEF_CNT_W,
    parameter int SUM_W = DEF_SUM_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_samples,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PW-1:0]    p_approx,
    input  logic [PW-1:0]    p_exact,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sample_count,
    output logic [CNT_W-1:0] err_count,
    output logic [SUM_W-1:0] sum_ed,
    output logic [PW-1:0]    max_ed
);
    state_t           state, state_nx;
    logic [CNT_W-1:0] target, accepted;
    logic [PW-1:0]    ed, s1_ed;
    logic             s1_valid, accept, launch, last;

    error_distance #(.W(PW)) u_ed (.a(p_approx), .b(p_exact), .d(ed));

    assign in_ready = (state == RUN) && (accepted < target);
    assign accept   = in_valid && in_ready;
    assign last     = accept && (accepted == target - CNT_W'(1));
    // start only takes effect when no run is in progress
    assign launch   = start && (state == IDLE || state == DONE);
    assign busy     = (state == RUN) || (state == DRAIN);
    assign done     = state == DONE;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: state_nx = launch ? ((num_samples == '0) ? DONE : RUN) : state;
            RUN:        state_nx = last ? DRAIN : RUN;
            // S2 is the statistics register itself, so once S1 is empty the
            // final sample has landed and done can rise on this edge
            DRAIN:      state_nx = s1_valid ? DRAIN : DONE;
            default:    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            target       <= '0;
            accepted     <= '0;
            s1_valid     <= 1'b0;
            s1_ed        <= '0;
            sample_count <= '0;
            err_count    <= '0;
            sum_ed       <= '0;
            max_ed       <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) s1_ed <= ed;
            if (launch) begin
                target       <= num_samples;
                accepted     <= '0;
                sample_count <= '0;
                err_count    <= '0;
                sum_ed       <= '0;
                max_ed       <= '0;
            end else begin
                if (accept) accepted <= accepted + CNT_W'(1);
                if (s1_valid) begin
                    sample_count <= sample_count + CNT_W'(1);
                    if (|s1_ed) err_count <= err_count + CNT_W'(1);
                    sum_ed <= sum_ed + {{(SUM_W-PW){1'b0}}, s1_ed};
                    if (s1_ed > max_ed) max_ed <= s1_ed;
                end
            end
        end
    end
endmodule

// File: tb/tb_ed_stats_collector.sv
// tb_ed_stats_collector: table vectors, corner sequences and random runs against a reference model
module tb_ed_stats_collector;
    logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0;
    logic [31:0]  num_samples = '0;
    logic [127:0] p_approx = '0, p_exact = '0;
    logic         in_ready, busy, done;
    logic [31:0]  sample_count, err_count;
    logic [159:0] sum_ed;
    logic [127:0] max_ed;
    int           n_cmp = 0, n_fail = 0;

    typedef struct {
        int                n;
        logic [3:0][127:0] a;
        logic [3:0][127:0] b;
        logic [31:0]       e_err;
        logic [159:0]      e_sum;
        logic [127:0]      e_max;
    } vec_t;
    vec_t tbl[4];

    ed_stats_collector dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(in_ready), .p_approx(p_approx), .p_exact(p_exact),
        .busy(busy), .done(done), .sample_count(sample_count), .err_count(err_count),
        .sum_ed(sum_ed), .max_ed(max_ed)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_stats(input string nm, input logic [31:0] cnt, input logic [31:0] err,
                             input logic [159:0] sum, input logic [127:0] mx);
        chk({nm, "_cnt"}, sample_count, cnt);
        chk({nm, "_err"}, err_count, err);
        chk({nm, "_sum"}, sum_ed, sum);
        chk({nm, "_max"}, max_ed, mx);
    endtask

    task automatic do_start(input logic [31:0] n);
        num_samples = n;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [127:0] a, input logic [127:0] b);
        p_approx = a;
        p_exact  = b;
        in_valid = 1'b1;
        for (int k = 0; k < 50 && !in_ready; k++) tick();
        if (!in_ready) chk("send_ready_timeout", in_ready, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        for (int k = 0; k < 100 && !done; k++) tick();
        chk(nm, done, 1);
    endtask

    initial begin
        logic [127:0] big, ones;
        big  = 128'd1 << 100;
        ones = '1;
        tbl[0].n = 3;
        for (int i = 0; i < 4; i++) begin
            tbl[0].a[i] = 128'h1234_5678_9ABC_DEF0;
            tbl[0].b[i] = 128'h1234_5678_9ABC_DEF0;
        end
        tbl[0].e_err = 0; tbl[0].e_sum = 0; tbl[0].e_max = 0;
        tbl[1].n = 4;
        tbl[1].a[0] = 128'd10; tbl[1].b[0] = 128'd5;
        tbl[1].a[1] = 128'd77; tbl[1].b[1] = 128'd77;
        tbl[1].a[2] = 128'd0;  tbl[1].b[2] = big;
        tbl[1].a[3] = 128'd1;  tbl[1].b[3] = 128'd4;
        tbl[1].e_err = 3; tbl[1].e_sum = {32'd0, big} + 160'd8; tbl[1].e_max = big;
        tbl[2].n = 1;
        tbl[2].a = '0; tbl[2].b = '0; tbl[2].b[0] = 128'd7;
        tbl[2].e_err = 1; tbl[2].e_sum = 160'd7; tbl[2].e_max = 128'd7;
        tbl[3].n = 2;
        tbl[3].a = '0; tbl[3].b = '0;
        tbl[3].a[0] = ones; tbl[3].b[1] = ones;
        tbl[3].e_err = 2; tbl[3].e_sum = {31'd0, ones, 1'b0}; tbl[3].e_max = ones;

        tick(); tick();
        chk("rst_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;
        tick();
        chk_stats("rst", 0, 0, 0, 0);

        // reset in the middle of a run discards everything
        do_start(5);
        send(128'd9, 128'd1);
        send(128'd3, 128'd8);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_ready", in_ready, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk_stats("midrst", 0, 0, 0, 0);
        in_valid = 1'b1;
        tick(); tick();
        in_valid = 1'b0;
        chk("idle_valid_ignored", sample_count, 0);
        chk("idle_valid_busy", busy, 0);

        // table vectors, back-to-back samples; done exactly 2 cycles after last accept
        for (int i = 0; i < 4; i++) begin
            do_start(tbl[i].n);
            chk($sformatf("tbl%0d_busy", i), busy, 1);
            for (int j = 0; j < tbl[i].n; j++) send(tbl[i].a[j], tbl[i].b[j]);
            chk($sformatf("tbl%0d_ready_drop", i), in_ready, 0);
            tick();
            chk($sformatf("tbl%0d_done_early", i), done, 0);
            chk($sformatf("tbl%0d_cnt_pre", i), sample_count, tbl[i].n);
            tick();
            chk($sformatf("tbl%0d_done", i), done, 1);
            chk_stats($sformatf("tbl%0d", i), tbl[i].n, tbl[i].e_err, tbl[i].e_sum, tbl[i].e_max);
        end

        // gaps in in_valid: 1,0,1,0,1 -> exactly 3 accepted
        begin
            int acc;
            logic [4:0] pat;
            acc = 0;
            pat = 5'b10101;
            do_start(3);
            for (int c = 0; c < 5; c++) begin
                in_valid = pat[c];
                p_approx = 128'd20 + 128'(c);
                p_exact  = 128'd20;
                if (in_valid && in_ready) acc++;
                tick();
            end
            in_valid = 1'b0;
            chk("gap_accepted", acc, 3);
            chk("gap_ready_drop", in_ready, 0);
            chk("gap_done_t0", done, 0);
            tick();
            chk("gap_done_t1", done, 0);
            tick();
            chk("gap_done_t2", done, 1);
            chk_stats("gap", 3, 2, 160'd6, 128'd4);
        end

        // zero samples
        begin
            logic seen;
            seen = 1'b0;
            do_start(0);
            chk("zero_done", done, 1);
            in_valid = 1'b1;
            for (int c = 0; c < 3; c++) begin
                seen |= in_ready;
                tick();
            end
            in_valid = 1'b0;
            chk("zero_ready_never", seen, 0);
            chk_stats("zero", 0, 0, 0, 0);
        end

        // start during RUN ignored, then restart from DONE clears stats
        do_start(2);
        send(128'd100, 128'd1);
        num_samples = 32'd9;
        start = 1'b1;
        tick();
        start = 1'b0;
        send(128'd1, 128'd2);
        wait_done("ign_done");
        chk_stats("ign", 2, 2, 160'd100, 128'd99);
        do_start(1);
        chk_stats("restart_clr", 0, 0, 0, 0);
        chk("restart_busy", busy, 1);
        send(128'd7, 128'd0);
        wait_done("restart_done");
        chk_stats("restart", 1, 1, 160'd7, 128'd7);

        // random runs against a reference model
        for (int r = 0; r < 30; r++) begin
            int n, kind;
            logic [31:0]  m_err;
            logic [159:0] m_sum;
            logic [127:0] m_max, a, b, e;
            n = $urandom_range(1, 8);
            m_err = 0; m_sum = 0; m_max = 0;
            do_start(n);
            for (int j = 0; j < n; j++) begin
                for (int g = $urandom_range(0, 2); g > 0; g--) begin
                    num_samples = $urandom_range(1, 20);
                    start = ($urandom_range(0, 3) == 0);
                    tick();
                    start = 1'b0;
                end
                kind = $urandom_range(0, 3);
                a = {$urandom, $urandom, $urandom, $urandom};
                b = {$urandom, $urandom, $urandom, $urandom};
                if (kind == 0) b = a;
                if (kind == 1) b = a + 128'($urandom_range(0, 15)) - 128'd7;
                if (kind == 3) begin a = ones; b = 0; if ($urandom_range(0, 1) == 1) begin a = 0; b = ones; end end
                e = (a > b) ? a - b : b - a;
                m_sum += {32'd0, e};
                m_err += (e != 0) ? 32'd1 : 32'd0;
                if (e > m_max) m_max = e;
                send(a, b);
            end
            wait_done($sformatf("rnd%0d_done", r));
            chk_stats($sformatf("rnd%0d", r), n, m_err, m_sum, m_max);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
